// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder and its helpers.
package mdio_pkg;

  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST2,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA,
    S_END,
    S_SKIP
  } mdio_state_e;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// Register-file side of the MDIO responder: address, read/write strobes and data.
interface mdio_phy_responder_if;
  import mdio_pkg::*;

  logic [REGAD_W-1:0] reg_addr;
  logic               reg_rd_en;
  logic [DATA_W-1:0]  reg_rd_data;
  logic               reg_wr_en;
  logic [DATA_W-1:0]  reg_wr_data;
  logic               busy;

  modport master (
    output reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy,
    input  reg_rd_data
  );

  modport slave (
    input  reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy,
    output reg_rd_data
  );

endinterface

// File: rtl/mdio_edge_sync.sv
// Synchronises MDC/MDIO into the local clock and flags each MDC rising edge.
module mdio_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_50m,
  input  logic reset_n,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_sync
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_prev;

  // Reset to the idle-high level so a line already high at release is not seen as a rise.
  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      mdc_q    <= '1;
      mdio_q   <= '1;
      mdc_prev <= 1'b1;
    end else begin
      mdc_q[0]  <= mdc;
      mdio_q[0] <= mdio;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        mdc_q[i]  <= mdc_q[i-1];
        mdio_q[i] <= mdio_q[i-1];
      end
      mdc_prev <= mdc_q[SYNC_STAGES-1];
    end
  end

  assign mdc_rise  = mdc_q[SYNC_STAGES-1] & ~mdc_prev;
  assign mdio_sync = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: decodes frames for PHY_ADDR into register-file strobes
// and drives read data back on MDIO.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR    = 5'h01,
  parameter int unsigned        PRE_MIN     = 32,
  parameter int unsigned        SYNC_STAGES = 2
) (
  input  logic                 clock_50m,
  input  logic                 reset_n,
  input  logic                 mdc,
  inout  wire                  mdio,
  mdio_phy_responder_if.master regs
);

  localparam int unsigned         CNT_W      = $clog2(PRE_MIN + 1);
  localparam logic [CNT_W-1:0]    PRE_MAX    = CNT_W'(PRE_MIN);
  localparam logic [3:0]          LAST_FIELD = 4'(PHYAD_W - 1);
  localparam logic [3:0]          LAST_DATA  = 4'(DATA_W - 1);

  logic mdc_rise;
  logic mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_50m (clock_50m),
    .reset_n   (reset_n),
    .mdc       (mdc),
    .mdio      (mdio),
    .mdc_rise  (mdc_rise),
    .mdio_sync (mdio_s)
  );

  mdio_state_e        state, state_n;
  logic [CNT_W-1:0]   pre_cnt, pre_cnt_n;
  logic [3:0]         bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]  shreg, shreg_n;
  logic               is_read, is_read_n;
  logic               ignore, ignore_n;
  logic               mdio_oe, mdio_oe_n;
  logic               mdio_out, mdio_out_n;
  logic [REGAD_W-1:0] addr_n;
  logic [DATA_W-1:0]  wr_data_n;
  logic               rd_en_n, wr_en_n, busy_n;
  logic               rd_en_d;

  assign mdio = mdio_oe ? mdio_out : 1'bz;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      pre_cnt          <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      is_read          <= 1'b0;
      ignore           <= 1'b0;
      mdio_oe          <= 1'b0;
      mdio_out         <= 1'b0;
      rd_en_d          <= 1'b0;
      regs.reg_addr    <= '0;
      regs.reg_wr_data <= '0;
      regs.reg_rd_en   <= 1'b0;
      regs.reg_wr_en   <= 1'b0;
      regs.busy        <= 1'b0;
    end else begin
      state            <= state_n;
      pre_cnt          <= pre_cnt_n;
      bit_cnt          <= bit_cnt_n;
      shreg            <= shreg_n;
      is_read          <= is_read_n;
      ignore           <= ignore_n;
      mdio_oe          <= mdio_oe_n;
      mdio_out         <= mdio_out_n;
      rd_en_d          <= regs.reg_rd_en;
      regs.reg_addr    <= addr_n;
      regs.reg_wr_data <= wr_data_n;
      regs.reg_rd_en   <= rd_en_n;
      regs.reg_wr_en   <= wr_en_n;
      regs.busy        <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    pre_cnt_n  = pre_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    is_read_n  = is_read;
    ignore_n   = ignore;
    mdio_oe_n  = mdio_oe;
    mdio_out_n = mdio_out;
    addr_n     = regs.reg_addr;
    wr_data_n  = regs.reg_wr_data;
    rd_en_n    = 1'b0;
    wr_en_n    = 1'b0;
    busy_n     = regs.busy;

    if (rd_en_d) shreg_n = regs.reg_rd_data;

    // END is left on the next clock rather than the next MDC edge, so the
    // first preamble bit of a back-to-back frame is not swallowed.
    if (state == S_END) begin
      mdio_oe_n = 1'b0;
      busy_n    = 1'b0;
      pre_cnt_n = '0;
      state_n   = S_IDLE;
    end else if (mdc_rise) begin
      case (state)
        S_IDLE, S_SKIP: begin
          if (mdio_s != ST_PATTERN[1]) begin
            if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 1'b1;
          end else if (pre_cnt == PRE_MAX) begin
            state_n   = S_ST2;
            busy_n    = 1'b1;
            pre_cnt_n = '0;
          end else begin
            pre_cnt_n = '0;
          end
        end
        S_ST2: begin
          bit_cnt_n = '0;
          if (mdio_s == ST_PATTERN[0]) begin
            state_n = S_OP;
          end else begin
            state_n   = S_IDLE;
            busy_n    = 1'b0;
            pre_cnt_n = '0;
          end
        end
        S_OP: begin
          shreg_n   = {shreg[DATA_W-2:0], mdio_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd1) begin
            bit_cnt_n = '0;
            if ({shreg[0], mdio_s} == OP_READ) begin
              is_read_n = 1'b1;
              state_n   = S_PHYAD;
            end else if ({shreg[0], mdio_s} == OP_WRITE) begin
              is_read_n = 1'b0;
              state_n   = S_PHYAD;
            end else begin
              state_n   = S_SKIP;
              busy_n    = 1'b0;
              pre_cnt_n = '0;
            end
          end
        end
        S_PHYAD: begin
          shreg_n   = {shreg[DATA_W-2:0], mdio_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == LAST_FIELD) begin
            bit_cnt_n = '0;
            ignore_n  = ({shreg[PHYAD_W-2:0], mdio_s} != PHY_ADDR);
            state_n   = S_REGAD;
          end
        end
        S_REGAD: begin
          shreg_n   = {shreg[DATA_W-2:0], mdio_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == LAST_FIELD) begin
            bit_cnt_n = '0;
            addr_n    = {shreg[REGAD_W-2:0], mdio_s};
            rd_en_n   = is_read && !ignore;
            state_n   = S_TA;
          end
        end
        S_TA: begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd0) begin
            if (is_read) begin
              if (!ignore) begin
                mdio_oe_n  = 1'b1;
                mdio_out_n = 1'b0;
              end
            end else if (mdio_s != 1'b1) begin
              state_n   = S_SKIP;
              busy_n    = 1'b0;
              pre_cnt_n = '0;
            end
          end else begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
            if (is_read) begin
              if (!ignore) begin
                mdio_out_n = shreg[DATA_W-1];
                shreg_n    = {shreg[DATA_W-2:0], 1'b0};
              end
            end else if (mdio_s != 1'b0) begin
              state_n   = S_SKIP;
              busy_n    = 1'b0;
              pre_cnt_n = '0;
            end
          end
        end
        S_DATA: begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (is_read) begin
            if (bit_cnt == LAST_DATA) begin
              mdio_oe_n = 1'b0;
              state_n   = S_END;
            end else if (!ignore) begin
              mdio_out_n = shreg[DATA_W-1];
              shreg_n    = {shreg[DATA_W-2:0], 1'b0};
            end
          end else begin
            shreg_n = {shreg[DATA_W-2:0], mdio_s};
            if (bit_cnt == LAST_DATA) begin
              if (!ignore) begin
                wr_data_n = {shreg[DATA_W-2:0], mdio_s};
                wr_en_n   = 1'b1;
              end
              state_n = S_END;
            end
          end
        end
        default: begin
          state_n   = S_IDLE;
          mdio_oe_n = 1'b0;
          busy_n    = 1'b0;
          pre_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder acting as an MDIO initiator plus register file.
`timescale 1ns/1ps
module tb_mdio_phy_responder;
  import mdio_pkg::*;

  localparam int unsigned HALF = 200;

  logic clock_50m = 1'b0;
  logic reset_n;
  logic mdc;
  logic tb_oe;
  logic tb_do;
  wire  mdio;

  assign mdio = tb_oe ? tb_do : 1'bz;

  mdio_phy_responder_if rf ();

  mdio_phy_responder #(
    .PHY_ADDR    (5'h01),
    .PRE_MIN     (32),
    .SYNC_STAGES (2)
  ) dut (
    .clock_50m (clock_50m),
    .reset_n   (reset_n),
    .mdc       (mdc),
    .mdio      (mdio),
    .regs      (rf)
  );

  always #10 clock_50m = ~clock_50m;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file model: data valid only in the cycle after reg_rd_en.
  logic [15:0] rd_value;
  always @(posedge clock_50m) rf.reg_rd_data <= rf.reg_rd_en ? rd_value : 16'hDEAD;

  int          wr_cnt, rd_cnt, oe_cnt;
  logic        busy_seen;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_dat;

  always @(negedge clock_50m) begin
    if (rf.reg_wr_en) begin
      wr_cnt++;
      wr_addr = rf.reg_addr;
      wr_dat  = rf.reg_wr_data;
    end
    if (rf.reg_rd_en) begin
      rd_cnt++;
      rd_addr = rf.reg_addr;
    end
    if (rf.reg_rd_en || rf.reg_wr_en)
      check_vec("strobe_excl", 32'(rf.reg_rd_en & rf.reg_wr_en), 32'h0);
    if (dut.mdio_oe) oe_cnt++;
    if (rf.busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; oe_cnt = 0; busy_seen = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_dat = '0;
  endtask

  task automatic mdc_cycle(input logic drv, input logic val, output logic samp, output logic oe_seen);
    tb_oe = drv;
    tb_do = val;
    #(HALF);
    samp    = mdio;
    oe_seen = dut.mdio_oe;
    mdc     = 1'b1;
    #(HALF);
    mdc     = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    logic s, o;
    for (int i = n - 1; i >= 0; i--) mdc_cycle(1'b1, bits[i], s, o);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send_bits(32'h1, 1);
  endtask

  task automatic header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg);
    send_bits(32'({ST_PATTERN, op, phy, rg}), 14);
  endtask

  task automatic write_frame(input logic [4:0] phy, input logic [4:0] rg,
                             input logic [1:0] ta, input logic [15:0] data);
    header(OP_WRITE, phy, rg);
    send_bits(32'(ta), 2);
    send_bits(32'(data), 16);
    send_bits(32'h3, 2);
  endtask

  task automatic read_response(output logic ta1_oe, output logic ta2_oe, output logic ta2_v,
                               output logic [15:0] word, output logic oe_all, output logic post_oe);
    logic s, o;
    mdc_cycle(1'b0, 1'b1, s, o); ta1_oe = o;
    mdc_cycle(1'b0, 1'b1, s, o); ta2_oe = o; ta2_v = s;
    oe_all = 1'b1;
    word   = '0;
    for (int i = 0; i < 16; i++) begin
      mdc_cycle(1'b0, 1'b1, s, o);
      word   = {word[14:0], s};
      oe_all = oe_all & o;
    end
    mdc_cycle(1'b1, 1'b1, s, o); post_oe = o;
  endtask

  logic        ta1_oe, ta2_oe, ta2_v, oe_all, post_oe, s, o;
  logic [15:0] word;

  initial begin
    reset_n = 1'b0; mdc = 1'b0; tb_oe = 1'b1; tb_do = 1'b1; rd_value = '0;
    clear_mon();
    repeat (4) @(negedge clock_50m);
    check_vec("rst_addr",    32'(rf.reg_addr),    32'h0);
    check_vec("rst_wr_data", 32'(rf.reg_wr_data), 32'h0);
    check_vec("rst_rd_en",   32'(rf.reg_rd_en),   32'h0);
    check_vec("rst_wr_en",   32'(rf.reg_wr_en),   32'h0);
    check_vec("rst_busy",    32'(rf.busy),        32'h0);
    check_vec("rst_oe",      32'(dut.mdio_oe),    32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock_50m);

    // Write 0x1340 to reg 0
    clear_mon();
    preamble(32);
    write_frame(5'h01, 5'h00, 2'b10, 16'h1340);
    check_vec("w1_count", 32'(wr_cnt), 32'd1);
    check_vec("w1_addr",  32'(wr_addr), 32'h00);
    check_vec("w1_data",  32'(wr_dat), 32'h1340);
    check_vec("w1_oe",    32'(oe_cnt), 32'd0);
    check_vec("w1_rd",    32'(rd_cnt), 32'd0);
    check_vec("w1_busy_seen", 32'(busy_seen), 32'h1);
    check_vec("w1_busy_end",  32'(rf.busy), 32'h0);

    // Read reg 1 returning 0x796D
    clear_mon();
    rd_value = 16'h796D;
    preamble(34);
    header(OP_READ, 5'h01, 5'h01);
    read_response(ta1_oe, ta2_oe, ta2_v, word, oe_all, post_oe);
    check_vec("r1_ta1_z",  32'(ta1_oe), 32'h0);
    check_vec("r1_ta2_oe", 32'(ta2_oe), 32'h1);
    check_vec("r1_ta2_v",  32'(ta2_v),  32'h0);
    check_vec("r1_data",   32'(word),   32'h796D);
    check_vec("r1_oe_all", 32'(oe_all), 32'h1);
    check_vec("r1_post_z", 32'(post_oe), 32'h0);
    check_vec("r1_rd_cnt", 32'(rd_cnt), 32'd1);
    check_vec("r1_rd_addr", 32'(rd_addr), 32'h01);
    check_vec("r1_wr_cnt", 32'(wr_cnt), 32'd0);
    check_vec("r1_busy_end", 32'(rf.busy), 32'h0);

    // Read to a foreign PHY address
    clear_mon();
    preamble(32);
    header(OP_READ, 5'h03, 5'h01);
    read_response(ta1_oe, ta2_oe, ta2_v, word, oe_all, post_oe);
    check_vec("mm_oe",     32'(oe_cnt), 32'd0);
    check_vec("mm_rd",     32'(rd_cnt), 32'd0);
    check_vec("mm_wr",     32'(wr_cnt), 32'd0);
    check_vec("mm_busy_seen", 32'(busy_seen), 32'h1);
    check_vec("mm_busy_end",  32'(rf.busy), 32'h0);

    // 31-one preamble must not open a frame
    send_bits(32'h0, 1);
    clear_mon();
    preamble(31);
    write_frame(5'h01, 5'h1F, 2'b10, 16'hFFFF);
    check_vec("sp_wr",   32'(wr_cnt), 32'd0);
    check_vec("sp_busy", 32'(busy_seen), 32'h0);
    check_vec("sp_oe",   32'(oe_cnt), 32'd0);

    // Bad write turnaround, then a good write
    clear_mon();
    preamble(32);
    write_frame(5'h01, 5'h05, 2'b11, 16'h8B85);
    check_vec("bt_wr",    32'(wr_cnt), 32'd0);
    check_vec("bt_state", 32'(dut.state), 32'(S_SKIP));
    check_vec("bt_busy",  32'(rf.busy), 32'h0);
    preamble(32);
    write_frame(5'h01, 5'h06, 2'b10, 16'h0AE2);
    check_vec("bt2_count", 32'(wr_cnt), 32'd1);
    check_vec("bt2_addr",  32'(wr_addr), 32'h06);
    check_vec("bt2_data",  32'(wr_dat), 32'h0AE2);

    // Reset while the responder drives read data bit 7
    clear_mon();
    rd_value = 16'h5A5A;
    preamble(32);
    header(OP_READ, 5'h01, 5'h02);
    mdc_cycle(1'b0, 1'b1, s, o);
    mdc_cycle(1'b0, 1'b1, s, o);
    word = '0;
    for (int i = 0; i < 8; i++) begin
      mdc_cycle(1'b0, 1'b1, s, o);
      word = {word[14:0], s};
    end
    check_vec("ra_hi_byte", 32'(word), 32'h005A);
    check_vec("ra_pre_oe",  32'(dut.mdio_oe), 32'h1);
    #7;
    reset_n = 1'b0;
    #1;
    check_vec("ra_oe_async", 32'(dut.mdio_oe), 32'h0);
    check_vec("ra_busy",     32'(rf.busy), 32'h0);
    check_vec("ra_addr",     32'(rf.reg_addr), 32'h0);
    tb_oe = 1'b1; tb_do = 1'b1;
    repeat (3) @(negedge clock_50m);
    reset_n = 1'b1;
    repeat (3) @(negedge clock_50m);
    clear_mon();
    preamble(32);
    write_frame(5'h01, 5'h0A, 2'b10, 16'h55AA);
    check_vec("ra2_count", 32'(wr_cnt), 32'd1);
    check_vec("ra2_addr",  32'(wr_addr), 32'h0A);
    check_vec("ra2_data",  32'(wr_dat), 32'h55AA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
